ks_arbiter: RTL and testbench
=============================

# ks_arbiter

Shares one 128-bit keystream source (the ChaCha keystream unit, or the AES-CTR keystream path in AES mode) among NUM_REQ datapath requesters. Round-robin grants with bounded bursts; one block outstanding at a time. Drives the source's level-held request and routes each returned keystream word to the granted requester. A watchdog reports a lost response as an error, and late responses are counted and discarded.

## Interface
- NUM_REQ, 4: number of requesters, legal 2..8
- MAX_BURST, 4: consecutive blocks one requester may take while others wait, legal 1..16
- TIMEOUT, 256: cycles to wait for up_valid before an error, legal 4..65535
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester level request; held until that requester's rsp_valid or rsp_err
- gnt  out  NUM_REQ  one-hot, registered; high while the block is outstanding
- rsp_valid  out  NUM_REQ  one-cycle pulse on the granted requester's bit
- rsp_err  out  NUM_REQ  one-cycle pulse on timeout, granted requester's bit
- rsp_data  out  128  keystream word, valid with rsp_valid; 0 otherwise
- up_req  out  1  level request to the keystream source
- up_valid  in  1  one-cycle pulse from the source
- up_data  in  128  keystream from the source, qualified by up_valid
- busy  out  1  high in any state other than IDLE
- drop_cnt  out  16  saturating count of up_valid pulses with nothing outstanding

## Operation
- States:
  - IDLE: no block outstanding; arbitrate.
  - ISSUE: up_req high; waiting for up_valid.
  - GAP: one cycle with up_req low.
- IDLE → ISSUE when any req bit is high.
  - The winner is registered into gnt, and up_req is set, on the same edge.
- ISSUE → GAP on up_valid.
  - Register rsp_data = up_data and pulse rsp_valid[winner].
- ISSUE → GAP when the watchdog reaches TIMEOUT-1 with no up_valid.
  - Pulse rsp_err[winner]; rsp_data stays 0.
  - If up_valid and timeout land in the same cycle, valid wins and no error is raised.
- GAP → IDLE unconditionally.
  - The gap matches the source's one-cycle post-output state.
  - It ensures a still-high up_req is never taken as a new request.
- Watchdog:
  - Width is clog2(TIMEOUT).
  - Cleared on entry to ISSUE; increments every ISSUE cycle.
- Arbitration:
  - Round-robin pointer gives priority starting at (last winner + 1) mod NUM_REQ.
  - Pointer is 0 after reset.
- Burst:
  - If the last winner still requests and burst_cnt < MAX_BURST, it is regranted and burst_cnt increments.
  - Otherwise the round-robin winner is taken; burst_cnt becomes 1 when the winner changes.
  - If the last winner is the only requester, it is always regranted and burst_cnt saturates at MAX_BURST.
  - A timeout ends the burst: burst_cnt is set to MAX_BURST.
- Drops:
  - up_valid in IDLE or GAP increments drop_cnt, saturating at 0xFFFF.
  - The data is discarded.
  - This covers late responses after a timeout or a reset.
- A req bit falling while its block is outstanding does not cancel the block. The response is still delivered.

## Timing
- Reset values:
  - state IDLE; gnt, rsp_valid, rsp_err 0; rsp_data 0; up_req 0; busy 0.
  - drop_cnt 0; pointer 0; burst_cnt 0; watchdog 0.
- Reset mid-ISSUE:
  - up_req drops on the reset edge and no response is delivered.
  - A later up_valid is counted as a drop.
- Arbitration latency: req high in IDLE at cycle c gives gnt and up_req high at c+1.
- Response latency: up_valid at cycle t gives rsp_valid and rsp_data at t+1, with up_req low at t+1 (GAP).
- Back-to-back: state is IDLE at t+2, and the next up_req is high at t+3 at the earliest.
- The minimum interval between up_req rising edges is therefore 3 cycles plus the source latency.
- All outputs are registered.

## Structure
- Shared package ks_pkg holds:
  - the KS_W = 128 constant;
  - the state encodings KS_ARB_IDLE, KS_ARB_ISSUE, KS_ARB_GAP;
  - the clog2 function.
- The chacha and aes keystream blocks reuse KS_W.
- Sub-module rr_pick: combinational round-robin select.
  - Inputs: req, pointer.
  - Outputs: one-hot grant and binary index.
  - Parameterised by NUM_REQ; unit-tested standalone.

## Test plan
- Single requester: req=4'b0001, source replies 5 cycles after up_req.
  - Required: rsp_valid[0] with the matching up_data one cycle after up_valid; up_req low in GAP.
- All four requesting, MAX_BURST=1.
  - Required: grant order 0,1,2,3,0; each rsp_data routed to the correct bit; no overlap of gnt.
- Burst: req[2] held, req[0] asserted, MAX_BURST=4.
  - Required: requester 2 served 4 times, then requester 0, then back to 2.
- Timeout, TIMEOUT=8, source silent.
  - Required: rsp_err pulses on the granted bit 8 cycles after up_req rises.
  - A later up_valid makes drop_cnt=1, with no rsp_valid.
- Same-cycle up_valid with watchdog at TIMEOUT-1.
  - Required: rsp_valid only, no rsp_err.
- rst asserted during ISSUE.
  - Required: all outputs 0 next cycle, and the pointer returns to 0.
  - A subsequent stray up_valid makes drop_cnt=1.
  - req=4'b1010 after reset grants requester 1 first.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg: definitions shared by the keystream blocks and the arbiter.
//   KS_W           keystream word width
//   ks_arb_state_t arbiter FSM encoding (IDLE / ISSUE / GAP)
//   clog2()        ceiling log2, used for parameter-derived widths
package ks_pkg;

    localparam int KS_W = 128;

    typedef enum logic [1:0] {
        KS_ARB_IDLE  = 2'd0,
        KS_ARB_ISSUE = 2'd1,
        KS_ARB_GAP   = 2'd2
    } ks_arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ks_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select.
//   i_req  per-requester request bits
//   i_ptr  index holding highest priority this round
//   o_gnt  one-hot grant (first requester at or after i_ptr, wrapping)
//   o_idx  binary index of the granted requester
//   o_any  any request present
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = ks_pkg::clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = IW'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ks_arbiter.sv
// ks_arbiter: shares one keystream source among NUM_REQ requesters.
// Round-robin with bounded bursts, one block outstanding, watchdog on the
// source response, late responses counted in drop_cnt and discarded.
//   clk, rst            clock, synchronous active-high reset
//   req                 per-requester level request
//   gnt                 one-hot grant, high while the block is outstanding
//   rsp_valid/rsp_err   one-cycle pulses on the granted bit
//   rsp_data            keystream word with rsp_valid, else 0
//   up_req              level request to the source
//   up_valid/up_data    source response
//   busy                FSM not idle
//   drop_cnt            saturating count of unsolicited up_valid pulses
module ks_arbiter
    import ks_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [NUM_REQ-1:0] rsp_err,
    output logic [KS_W-1:0]    rsp_data,
    output logic               up_req,
    input  logic               up_valid,
    input  logic [KS_W-1:0]    up_data,
    output logic               busy,
    output logic [15:0]        drop_cnt
);

    localparam int IW = clog2(NUM_REQ);
    localparam int BW = clog2(MAX_BURST + 1);
    localparam int WW = clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQ - 1);

    ks_arb_state_t      r_state, w_state_n;
    logic [IW-1:0]      r_ptr, w_ptr_n, r_last, w_last_n, w_win;
    logic [BW-1:0]      r_burst, w_burst_n;
    logic [WW-1:0]      r_wd, w_wd_n;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_n;
    logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_n, r_rsp_err, w_rsp_err_n;
    logic [KS_W-1:0]    r_rsp_data, w_rsp_data_n;
    logic               r_up_req, r_busy;
    logic [15:0]        r_drop, w_drop_n, w_drop_inc;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_any;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_drop_inc = (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;

    always_comb begin
        w_state_n     = r_state;
        w_ptr_n       = r_ptr;
        w_last_n      = r_last;
        w_burst_n     = r_burst;
        w_wd_n        = r_wd;
        w_gnt_n       = r_gnt;
        w_rsp_valid_n = '0;
        w_rsp_err_n   = '0;
        w_rsp_data_n  = '0;
        w_drop_n      = r_drop;
        w_win         = r_last;
        unique case (r_state)
            KS_ARB_IDLE: begin
                if (up_valid) w_drop_n = w_drop_inc;
                if (w_pick_any) begin
                    w_state_n = KS_ARB_ISSUE;
                    w_wd_n    = '0;
                    if (req[r_last] && r_burst < BURST_MAX) begin
                        w_win     = r_last;
                        w_burst_n = r_burst + 1'b1;
                    end else begin
                        // Round-robin winner equal to last winner means it is
                        // the sole requester: keep serving it, count pinned.
                        w_win     = w_pick_idx;
                        w_burst_n = (w_pick_idx == r_last) ? BURST_MAX : BW'(1);
                    end
                    w_last_n = w_win;
                    w_gnt_n  = '0;
                    w_gnt_n[w_win] = 1'b1;
                    w_ptr_n  = (w_win == IDX_LAST) ? '0 : w_win + 1'b1;
                end
            end
            KS_ARB_ISSUE: begin
                // up_valid takes precedence over a same-cycle timeout
                if (up_valid) begin
                    w_state_n     = KS_ARB_GAP;
                    w_rsp_valid_n = r_gnt;
                    w_rsp_data_n  = up_data;
                    w_gnt_n       = '0;
                end else if (r_wd == WD_LAST) begin
                    w_state_n   = KS_ARB_GAP;
                    w_rsp_err_n = r_gnt;
                    w_gnt_n     = '0;
                    w_burst_n   = BURST_MAX;
                end else begin
                    w_wd_n = r_wd + 1'b1;
                end
            end
            KS_ARB_GAP: begin
                // One dead cycle so a still-high source request is never
                // mistaken for a new one.
                w_state_n = KS_ARB_IDLE;
                if (up_valid) w_drop_n = w_drop_inc;
            end
            default: w_state_n = KS_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= KS_ARB_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_last      <= '0;
            r_burst     <= '0;
            r_wd        <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            r_rsp_data  <= '0;
            r_up_req    <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_ptr       <= w_ptr_n;
            r_last      <= w_last_n;
            r_burst     <= w_burst_n;
            r_wd        <= w_wd_n;
            r_gnt       <= w_gnt_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_err   <= w_rsp_err_n;
            r_rsp_data  <= w_rsp_data_n;
            r_up_req    <= (w_state_n == KS_ARB_ISSUE);
            r_busy      <= (w_state_n != KS_ARB_IDLE);
            r_drop      <= w_drop_n;
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign up_req    = r_up_req;
    assign busy      = r_busy;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_ks_arbiter.sv
// tb_ks_arbiter: scenario tasks against a behavioural arbitration model.
module tb_ks_arbiter;

    localparam int NR   = 4;
    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR-1:0]  gnt, rsp_valid, rsp_err;
    logic [127:0]   rsp_data;
    logic           up_req;
    logic           up_valid = 1'b0;
    logic [127:0]   up_data = '0;
    logic           busy;
    logic [15:0]    drop_cnt;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_ptr, m_last, m_burst, m_drop;

    ks_arbiter #(.NUM_REQ(NR), .MAX_BURST(MAXB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_data(rsp_data), .up_req(up_req),
        .up_valid(up_valid), .up_data(up_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_ptr = 0; m_last = 0; m_burst = 0; m_drop = 0;
    endtask

    // Winner: last winner again while its burst allowance lasts, otherwise
    // the first requester scanning upward from the pointer.
    task automatic m_grant(input logic [NR-1:0] r, output int w);
        w = -1;
        if (r[m_last] && m_burst < MAXB) begin
            w = m_last;
            m_burst = m_burst + 1;
        end else begin
            for (int k = 0; k < NR; k++)
                if (w < 0 && r[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            m_burst = (w == m_last) ? MAXB : 1;
        end
        m_ptr  = (w + 1) % NR;
        m_last = w;
    endtask

    // Plays the keystream source for one block; returns what was observed.
    task automatic run_block(input int lat, input bit silent, output bit ok,
                             output logic [NR-1:0] g, output logic [127:0] sent,
                             output logic [NR-1:0] v, output logic [NR-1:0] e,
                             output logic [127:0] d, output logic upr, output int n);
        int k;
        ok = 1'b0; g = '0; v = '0; e = '0; d = '0; upr = 1'b0; n = 0;
        sent = {$urandom(), $urandom(), $urandom(), $urandom()};
        k = 0;
        while (!up_req && k < 10) begin tick(); k++; end
        if (!up_req) return;
        g = gnt;
        if (!silent) begin
            repeat (lat - 1) tick();
            up_valid = 1'b1; up_data = sent;
            tick();
            up_valid = 1'b0; up_data = '0;
            n = lat;
        end else begin
            while (rsp_valid == '0 && rsp_err == '0 && n < 20) begin tick(); n++; end
        end
        v = rsp_valid; e = rsp_err; d = rsp_data; upr = up_req;
        ok = ((v | e) != '0);
        req = req & ~g;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; up_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt); end
        total++; if (up_req !== 1'b0) begin bad++; $display("FAIL reset_up_req got=%b want=0", up_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ((rsp_valid | rsp_err) !== '0) begin bad++; $display("FAIL reset_rsp got=%b/%b want=0", rsp_valid, rsp_err); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rsp_data); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_single();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        req = 4'b0001;
        m_grant(req, w); x = '0; x[w] = 1'b1;
        run_block(5, 1'b0, ok, g, s, v, e, d, upr, n);
        total++; if (g !== x) begin bad++; $display("FAIL single_gnt got=%b want=%b", g, x); end
        total++; if (v !== x) begin bad++; $display("FAIL single_vld got=%b want=%b", v, x); end
        total++; if (d !== s) begin bad++; $display("FAIL single_data got=%h want=%h", d, s); end
        total++; if (upr !== 1'b0 || e !== '0) begin bad++; $display("FAIL single_gap got up_req=%b err=%b want 0/0", upr, e); end
        tick();
        total++; if (rsp_valid !== '0 || rsp_data !== '0) begin bad++; $display("FAIL single_clear got=%b/%h want 0/0", rsp_valid, rsp_data); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        req = 4'b0001;
        m_grant(req, w);
        run_block(2, 1'b0, ok, g, s, v, e, d, upr, n);
        req = 4'b0001;
        tick();
        total++; if (busy !== 1'b0 || up_req !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b up_req=%b want 0/0", busy, up_req); end
        tick();
        total++; if (up_req !== 1'b1) begin bad++; $display("FAIL b2b_reissue got=%b want=1", up_req); end
        m_grant(req, w); x = '0; x[w] = 1'b1;
        run_block(4, 1'b0, ok, g, s, v, e, d, upr, n);
        total++; if (g !== x || v !== x || d !== s) begin bad++; $display("FAIL b2b_rsp got g=%b v=%b want %b", g, v, x); end
    endtask

    task automatic test_all_four();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) req = req | 4'b0001;
            m_grant(req, w); x = '0; x[w] = 1'b1;
            run_block($urandom_range(1, 7), 1'b0, ok, g, s, v, e, d, upr, n);
            total++; if (g !== x) begin bad++; $display("FAIL all4_gnt[%0d] got=%b want=%b", i, g, x); end
            total++; if (g !== 4'b0001 << (i % 4)) begin bad++; $display("FAIL all4_order[%0d] got=%b want idx %0d", i, g, i % 4); end
            total++; if (v !== x || d !== s) begin bad++; $display("FAIL all4_route[%0d] got v=%b d=%h want %b %h", i, v, d, x, s); end
            total++; if ($countones(g) != 1) begin bad++; $display("FAIL all4_onehot[%0d] got=%b want one bit", i, g); end
        end
    endtask

    task automatic test_burst();
        bit ok, pend0; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        logic [NR-1:0] exp_seq [6];
        exp_seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        pend0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req = 4'b0100 | (pend0 ? 4'b0001 : 4'b0000);
            m_grant(req, w); x = '0; x[w] = 1'b1;
            run_block($urandom_range(1, 7), 1'b0, ok, g, s, v, e, d, upr, n);
            total++; if (g !== x || g !== exp_seq[i]) begin bad++; $display("FAIL burst_gnt[%0d] got=%b want=%b", i, g, exp_seq[i]); end
            total++; if (v !== x || d !== s) begin bad++; $display("FAIL burst_rsp[%0d] got v=%b want %b", i, v, x); end
            if (i == 0) pend0 = 1'b1;
            if (g[0]) pend0 = 1'b0;
        end
    endtask

    task automatic test_timeout();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        req = 4'b0010;
        m_grant(req, w); x = '0; x[w] = 1'b1;
        run_block(0, 1'b1, ok, g, s, v, e, d, upr, n);
        m_burst = MAXB;
        total++; if (!ok) begin bad++; $display("FAIL to_seen got=none want rsp_err"); end
        total++; if (e !== x || v !== '0) begin bad++; $display("FAIL to_err got err=%b vld=%b want %b/0", e, v, x); end
        total++; if (n != TO) begin bad++; $display("FAIL to_latency got=%0d want=%0d", n, TO); end
        total++; if (d !== '0) begin bad++; $display("FAIL to_data got=%h want=0", d); end
        tick(); tick(); tick();
        up_valid = 1'b1; up_data = {4{$urandom()}};
        tick();
        up_valid = 1'b0; up_data = '0;
        m_drop++;
        total++; if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL to_drop got=%0d want=%0d", drop_cnt, m_drop); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL to_novld got=%b want=0", rsp_valid); end
    endtask

    task automatic test_same_cycle();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        req = 4'b1000;
        m_grant(req, w); x = '0; x[w] = 1'b1;
        run_block(TO, 1'b0, ok, g, s, v, e, d, upr, n);
        total++; if (v !== x || e !== '0) begin bad++; $display("FAIL same_cycle got vld=%b err=%b want %b/0", v, e, x); end
        total++; if (d !== s) begin bad++; $display("FAIL same_cycle_data got=%h want=%h", d, s); end
    endtask

    task automatic test_random();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w;
        for (int i = 0; i < 20; i++) begin
            req = NR'($urandom_range(1, 15));
            m_grant(req, w); x = '0; x[w] = 1'b1;
            run_block($urandom_range(1, 7), 1'b0, ok, g, s, v, e, d, upr, n);
            total++; if (g !== x) begin bad++; $display("FAIL rand_gnt[%0d] got=%b want=%b", i, g, x); end
            total++; if (v !== x || d !== s) begin bad++; $display("FAIL rand_rsp[%0d] got v=%b d=%h want %b %h", i, v, d, x, s); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [NR-1:0] g, v, e, x; logic [127:0] s, d; logic upr; int n, w, k;
        req = 4'b0100;
        k = 0;
        while (!up_req && k < 10) begin tick(); k++; end
        total++; if (up_req !== 1'b1) begin bad++; $display("FAIL rm_issue got=%b want=1", up_req); end
        tick(); tick();
        rst = 1'b1; req = '0;
        tick();
        total++; if (up_req !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rm_outs got up_req=%b gnt=%b busy=%b want 0", up_req, gnt, busy); end
        total++; if ((rsp_valid | rsp_err) !== '0 || rsp_data !== '0 || drop_cnt !== 16'd0) begin bad++; $display("FAIL rm_rsp got v=%b e=%b drop=%0d want 0", rsp_valid, rsp_err, drop_cnt); end
        rst = 1'b0;
        m_reset();
        tick();
        up_valid = 1'b1; up_data = {4{$urandom()}};
        tick();
        up_valid = 1'b0; up_data = '0;
        m_drop++;
        total++; if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL rm_drop got=%0d want=%0d", drop_cnt, m_drop); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rm_novld got=%b want=0", rsp_valid); end
        req = 4'b1010;
        m_grant(req, w); x = '0; x[w] = 1'b1;
        run_block(2, 1'b0, ok, g, s, v, e, d, upr, n);
        total++; if (g !== x || g !== 4'b0010) begin bad++; $display("FAIL rm_first_gnt got=%b want=0010", g); end
        total++; if (v !== x || d !== s) begin bad++; $display("FAIL rm_rsp_data got v=%b want %b", v, x); end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_all_four();
        test_burst();
        test_timeout();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
